// File: rtl/alu_pipe.sv
// Purpose: WIDTH-generic ALU with a registered, valid/ready result stage and a shift-add unsigned multiplier.
// Latency: single-cycle ops 1 clock (result after the accepting edge); MULTIPLY WIDTH clocks after acceptance.
// Backpressure: in_ready drops while multiplying or while a result is held with out_ready low; outputs stay stable.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_high,
  output logic             zero,
  output logic             sign,
  output logic             carry_out,
  output logic             overflow,
  output logic             illegal,
  output logic             busy
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_INC = 4'd2;
  localparam logic [3:0] OP_DEC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_ROR = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH:0]   ONE_X     = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   w_acc_step;
  logic                 w_mul_done;

  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_y;
  logic [WIDTH-1:0]     r_y_high;
  logic                 r_zero;
  logic                 r_sign;
  logic                 r_carry;
  logic                 r_ovf;
  logic                 r_illegal;

  logic                 w_accept;
  logic                 w_acc_single;
  logic                 w_acc_mul;

  logic [WIDTH:0]       w_ext;
  logic [WIDTH-1:0]     w_y;
  logic                 w_c;
  logic                 w_v;
  logic                 w_ill;

  // A new operation may enter only when idle and the result slot is empty or being drained this cycle.
  assign in_ready     = (r_state == S_IDLE) && (!r_out_valid || out_ready) && !reset;
  assign w_accept     = in_valid && in_ready;
  assign w_acc_mul    = w_accept && (operation == OP_MUL);
  assign w_acc_single = w_accept && (operation != OP_MUL);

  // One partial product per clock; on the last step this sum is the full product.
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);

  // State register; reset aborts any multiply in flight.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: enter MUL on a multiply acceptance, leave after the last iteration.
  always_comb begin
    w_state_nxt = r_state;
    w_mul_done  = 1'b0;
    case (r_state)
      S_IDLE: if (w_acc_mul) w_state_nxt = S_MUL;
      S_MUL: begin
        if (r_cnt == LAST_ITER) begin
          w_state_nxt = S_IDLE;
          w_mul_done  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift-add datapath: multiplicand moves left, multiplier right, one bit consumed per clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_acc_mul) begin
        r_cnt    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, a};
        r_mplier <= b;
        r_acc    <= '0;
      end
    end else begin
      r_cnt    <= r_cnt + 1'b1;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_acc_step;
    end
  end

  // Single-cycle result and carry/overflow; undefined opcodes fall to the illegal path.
  always_comb begin
    w_ext = '0;
    w_y   = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (operation)
      OP_ADD: begin
        w_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
        w_y   = w_ext[WIDTH-1:0];
        w_c   = w_ext[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Borrow shows up as the extra top bit of the widened difference.
        w_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_in};
        w_y   = w_ext[WIDTH-1:0];
        w_c   = w_ext[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_INC: begin
        w_ext = {1'b0, a} + ONE_X;
        w_y   = w_ext[WIDTH-1:0];
        w_c   = &a;
        w_v   = (a == MAX_POS);
      end
      OP_DEC: begin
        w_ext = {1'b0, a} - ONE_X;
        w_y   = w_ext[WIDTH-1:0];
        w_c   = (a == '0);
        w_v   = (a == MIN_NEG);
      end
      OP_AND: w_y = a & b;
      OP_OR:  w_y = a | b;
      OP_XOR: w_y = a ^ b;
      OP_NOT: w_y = ~a;
      OP_SHL: begin
        w_y = {a[WIDTH-2:0], 1'b0};
        w_c = a[WIDTH-1];
      end
      OP_SHR: begin
        w_y = {1'b0, a[WIDTH-1:1]};
        w_c = a[0];
      end
      OP_ROL: begin
        w_y = {a[WIDTH-2:0], carry_in};
        w_c = a[WIDTH-1];
      end
      OP_ROR: begin
        w_y = {carry_in, a[WIDTH-1:1]};
        w_c = a[0];
      end
      OP_MUL: w_ill = 1'b0;
      default: w_ill = 1'b1;
    endcase
  end

  // Result register: loads on single-cycle acceptance or multiply completion, else drains on out_ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_y_high    <= '0;
      r_zero      <= 1'b0;
      r_sign      <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_acc_single) begin
      r_out_valid <= 1'b1;
      r_y         <= w_y;
      r_y_high    <= '0;
      r_zero      <= (w_y == '0);
      r_sign      <= w_y[WIDTH-1];
      r_carry     <= w_c;
      r_ovf       <= w_v;
      r_illegal   <= w_ill;
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_y         <= w_acc_step[WIDTH-1:0];
      r_y_high    <= w_acc_step[2*WIDTH-1:WIDTH];
      r_zero      <= (w_acc_step == '0);
      r_sign      <= w_acc_step[2*WIDTH-1];
      r_carry     <= |w_acc_step[2*WIDTH-1:WIDTH];
      r_ovf       <= |w_acc_step[2*WIDTH-1:WIDTH];
      r_illegal   <= 1'b0;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign y_high    = r_y_high;
  assign zero      = r_zero;
  assign sign      = r_sign;
  assign carry_out = r_carry;
  assign overflow  = r_ovf;
  assign illegal   = r_illegal;
  assign busy      = (r_state == S_MUL);

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: WIDTH=8 instance checked every cycle against a queue-based arithmetic model,
// plus a WIDTH=16 instance for the wide multiply case.
module tb_alu_pipe;

  localparam int W = 8;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] yh;
    logic z, s, c, v, ill;
  } res_t;

  typedef struct {
    res_t r;
    int   due;
    bit   is_mul;
  } ent_t;

  logic       clock, reset;
  logic       in_valid, in_ready, carry_in, out_valid, out_ready;
  logic [3:0] operation;
  logic [7:0] a, b, y, y_high;
  logic       zero, sign, carry_out, overflow, illegal, busy;

  logic        h_in_valid, h_in_ready, h_carry_in, h_out_valid, h_out_ready;
  logic [3:0]  h_operation;
  logic [15:0] h_a, h_b, h_y, h_y_high;
  logic        h_zero, h_sign, h_carry_out, h_overflow, h_illegal, h_busy;

  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  bit   rand_bp = 0;
  ent_t q[$];

  alu_pipe #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .a(a), .b(b), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_high(y_high),
    .zero(zero), .sign(sign), .carry_out(carry_out), .overflow(overflow),
    .illegal(illegal), .busy(busy)
  );

  alu_pipe #(.WIDTH(16)) u_dut16 (
    .clock(clock), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .operation(h_operation), .a(h_a), .b(h_b), .carry_in(h_carry_in),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .y(h_y), .y_high(h_y_high),
    .zero(h_zero), .sign(h_sign), .carry_out(h_carry_out), .overflow(h_overflow),
    .illegal(h_illegal), .busy(h_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  function automatic res_t mk(int yv, int yhv, bit z, bit s, bit c, bit v, bit ill);
    res_t r;
    r.y = 8'(yv); r.yh = 8'(yhv);
    r.z = z; r.s = s; r.c = c; r.v = v; r.ill = ill;
    return r;
  endfunction

  // Reference behaviour from plain integer arithmetic on unsigned 0..255 operands.
  function automatic res_t model(int op, int av, int bv, int cin);
    res_t r;
    int sa, sb, t, p;
    r  = '0;
    sa = (av >= 128) ? av - 256 : av;
    sb = (bv >= 128) ? bv - 256 : bv;
    case (op)
      0: begin
        t = av + bv + cin;
        r.y = 8'(t % 256); r.c = (t >= 256);
        r.v = ((sa + sb + cin) > 127) || ((sa + sb + cin) < -128);
      end
      1: begin
        t = av - bv - cin;
        r.y = 8'((t + 512) % 256); r.c = (t < 0);
        r.v = ((sa - sb - cin) > 127) || ((sa - sb - cin) < -128);
      end
      2: begin r.y = 8'((av + 1) % 256);   r.c = (av == 255); r.v = (av == 127); end
      3: begin r.y = 8'((av + 255) % 256); r.c = (av == 0);   r.v = (av == 128); end
      4: r.y = 8'(av & bv);
      5: r.y = 8'(av | bv);
      6: r.y = 8'(av ^ bv);
      7: r.y = 8'(255 - av);
      8:  begin r.y = 8'((av * 2) % 256);       r.c = (av >= 128); end
      9:  begin r.y = 8'(av / 2);               r.c = (av % 2 == 1); end
      10: begin r.y = 8'((av * 2) % 256 + cin); r.c = (av >= 128); end
      11: begin r.y = 8'(av / 2 + cin * 128);   r.c = (av % 2 == 1); end
      12: begin
        p = av * bv;
        r.y = 8'(p % 256); r.yh = 8'(p / 256);
        r.z = (p == 0); r.s = (p >= 32768); r.c = (p >= 256); r.v = (p >= 256);
        return r;
      end
      default: begin
        r.z = 1'b1; r.ill = 1'b1;
        return r;
      end
    endcase
    r.z = (r.y == 0);
    r.s = (r.y >= 128);
    return r;
  endfunction

  // Every cycle out of reset: valid/busy/ready timing and the result at the head of the queue.
  bit ev, eb;
  always @(negedge clock) begin
    #2;
    if (!reset) begin
      ev = (q.size() > 0) && (cycle >= q[0].due);
      eb = (q.size() > 0) && q[0].is_mul && (cycle < q[0].due);
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(eb));
      chk("in_ready", 32'(in_ready), 32'(!eb && (!ev || out_ready)));
      if (out_valid && ev) begin
        chk("result", 32'({y, y_high, zero, sign, carry_out, overflow, illegal}), 32'(q[0].r));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic send(input int op, input int av, input int bv, input int cin);
    int acc_cycle;
    ent_t e;
    in_valid  = 1'b1;
    operation = 4'(op);
    a         = 8'(av);
    b         = 8'(bv);
    carry_in  = cin[0];
    if (rand_bp) out_ready = ($urandom % 4 != 0);
    for (int t = 0; ; t++) begin
      #1;
      if (in_ready) break;
      if (t >= 200) begin
        chk("accept_timeout", 32'(in_ready), 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
        return;
      end
      @(negedge clock);
      if (rand_bp) out_ready = ($urandom % 4 != 0);
    end
    acc_cycle = cycle;
    @(posedge clock);
    e.r      = model(op, av, bv, cin);
    e.is_mul = (op == 12);
    e.due    = acc_cycle + 1 + ((op == 12) ? W : 0);
    q.push_back(e);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (rand_bp) out_ready = ($urandom % 4 != 0);
      @(negedge clock);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] snap;
    reset = 1'b1; in_valid = 1'b0; operation = '0; a = '0; b = '0; carry_in = 1'b0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_operation = '0; h_a = '0; h_b = '0; h_carry_in = 1'b0; h_out_ready = 1'b1;

    // Pin the model against hand-computed values.
    chk("m_add_208_144", 32'(model(0, 208, 144, 0)), 32'(mk(96, 0, 0, 0, 1, 1, 0)));
    chk("m_add_208_48",  32'(model(0, 208, 48, 0)),  32'(mk(0, 0, 1, 0, 1, 0, 0)));
    chk("m_add_80_80",   32'(model(0, 80, 80, 0)),   32'(mk(160, 0, 0, 1, 0, 1, 0)));
    chk("m_sub_80_100",  32'(model(1, 80, 100, 0)),  32'(mk(236, 0, 0, 1, 1, 0, 0)));
    chk("m_sub_80_176",  32'(model(1, 80, 176, 0)),  32'(mk(160, 0, 0, 1, 1, 1, 0)));
    chk("m_sub_208_112", 32'(model(1, 208, 112, 0)), 32'(mk(96, 0, 0, 0, 0, 1, 0)));
    chk("m_add_255_c",   32'(model(0, 255, 0, 1)),   32'(mk(0, 0, 1, 0, 1, 0, 0)));
    chk("m_shl_136",     32'(model(8, 136, 0, 1)),   32'(mk(16, 0, 0, 0, 1, 0, 0)));
    chk("m_rol_8",       32'(model(10, 8, 0, 1)),    32'(mk(17, 0, 0, 0, 0, 0, 0)));
    chk("m_ror_9",       32'(model(11, 9, 0, 1)),    32'(mk(132, 0, 0, 1, 1, 0, 0)));
    chk("m_mul_200_150", 32'(model(12, 200, 150, 0)), 32'(mk(48, 117, 0, 0, 1, 1, 0)));
    chk("m_mul_0_77",    32'(model(12, 0, 77, 0)),   32'(mk(0, 0, 1, 0, 0, 0, 0)));
    chk("m_illegal_14",  32'(model(14, 3, 4, 1)),    32'(mk(0, 0, 1, 0, 0, 0, 1)));

    // Reset state.
    repeat (2) @(negedge clock);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_state", 32'({out_valid, y, y_high, zero, sign, carry_out, overflow, illegal, busy}), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Back-to-back adds, subtracts, carry chains, shifts and rotates.
    send(0, 208, 144, 0); send(0, 208, 48, 0); send(0, 80, 80, 0);
    send(1, 80, 100, 0);  send(1, 80, 176, 0); send(1, 208, 112, 0);
    send(0, 255, 0, 1);
    send(8, 136, 0, 1);   send(10, 8, 0, 1);   send(11, 9, 0, 1);

    // Multiply: count busy cycles, then look at the product directly.
    send(12, 200, 150, 0);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (!busy) break;
      n++;
      @(negedge clock);
    end
    chk("mul_busy_cycles", 32'(n), 32'd8);
    chk("mul_200_150", 32'({out_valid, y_high, y, carry_out, overflow}), 32'({1'b1, 8'd117, 8'd48, 1'b1, 1'b1}));
    @(negedge clock);
    send(12, 0, 77, 0);
    repeat (W + 1) @(negedge clock);

    // Backpressure: result held five cycles, queued input goes in as the old result drains.
    out_ready = 1'b0;
    send(0, 5, 6, 0);
    fork
      send(1, 50, 20, 0);
      begin
        #1;
        snap = 32'({y, y_high, zero, sign, carry_out, overflow, illegal});
        for (int k = 0; k < 5; k++) begin
          if (k > 0) #1;
          chk("bp_stable", 32'({y, y_high, zero, sign, carry_out, overflow, illegal}), snap);
          chk("bp_in_ready", 32'(in_ready), 32'd0);
          @(negedge clock);
        end
        out_ready = 1'b1;
      end
    join
    #1;
    chk("bp_new_result", 32'({out_valid, y}), 32'({1'b1, 8'd30}));
    @(negedge clock);

    // Reset during iteration 3 of a multiply drops it; the block then runs normally.
    send(12, 200, 150, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    q.delete();
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_idle", 32'({out_valid, busy}), 32'd0);
    @(negedge clock);
    send(0, 1, 1, 0);
    #1;
    chk("after_abort_add", 32'({out_valid, y}), 32'({1'b1, 8'd2}));
    @(negedge clock);
    send(14, 9, 9, 0);
    #1;
    chk("illegal_14", 32'({out_valid, illegal, zero}), 32'b111);
    @(negedge clock);

    // Randomised traffic with random backpressure.
    rand_bp = 1;
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 15);
      if ($urandom % 8 == 0) op = 12;
      send(op, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
      if ($urandom % 4 == 0) idle($urandom_range(1, 3));
    end
    rand_bp = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (q.size() == 0) break;
      @(negedge clock);
      #3;
    end
    chk("drain", 32'(q.size()), 32'd0);

    // WIDTH=16 multiply 300 x 300.
    @(negedge clock);
    h_in_valid = 1'b1; h_operation = 4'd12; h_a = 16'd300; h_b = 16'd300;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (h_in_ready) break;
      @(negedge clock);
    end
    chk("w16_accept", 32'(h_in_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    h_in_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (h_out_valid) break;
      if (!h_busy) begin
        chk("w16_busy", 32'(h_busy), 32'd1);
        break;
      end
      n++;
      @(negedge clock);
    end
    chk("w16_latency", 32'(n), 32'd16);
    chk("w16_lo", 32'(h_y), 32'd24464);
    chk("w16_hi", 32'(h_y_high), 32'd1);
    chk("w16_flags", 32'({h_out_valid, h_zero, h_sign, h_carry_out, h_overflow, h_illegal}), 32'b100110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the 8-bit combinational ALU. Adds a WIDTH-generic datapath, a registered output stage with valid/ready flow control, and a multi-cycle unsigned MULTIPLY producing a 2×WIDTH product. Sits between the instruction decoder (producer) and the register-file writeback (consumer). It issues one single-cycle operation per clock, or one multiply per WIDTH+1 clocks.

## Interface
- WIDTH, 8, operand/result width; legal range 4..32.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operation/operands valid.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready at a rising edge.
- operation  in  4  opcode, encoded as follows:
  - ADD=0, SUBTRACT=1, INCREMENT=2, DECREMENT=3
  - BIT_AND=4, BIT_OR=5, BIT_XOR=6, BIT_NOT=7
  - SHIFT_LEFT=8, SHIFT_RIGHT=9, ROTATE_LEFT=10, ROTATE_RIGHT=11
  - MULTIPLY=12; 13–15 illegal.
- a, b  in  WIDTH  operands.
- carry_in  in  1  carry/borrow/rotate input.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- y  out  WIDTH  result (low half for MULTIPLY).
- y_high  out  WIDTH  high half of product; 0 for all other ops.
- zero, sign, carry_out, overflow  out  1  status flags.
- illegal  out  1  result came from opcode 13–15.
- busy  out  1  multiply in progress.

## Operation
- States: IDLE, MUL. in_ready = (state==IDLE) && (!out_valid || out_ready) && !reset.
- ADD: y = a+b+carry_in. carry_out = bit WIDTH of the sum. overflow = signed overflow (a, b same sign, y differs).
- SUBTRACT: y = a−b−carry_in. carry_out = borrow (1 when a < b+carry_in unsigned). overflow = a, b differ in sign and y sign ≠ a sign.
- INCREMENT / DECREMENT: y = a±1; b and carry_in ignored.
  - INCREMENT: carry_out = (a == all-ones); overflow = (a == 0x7F..F).
  - DECREMENT: carry_out = (a == 0); overflow = (a == 0x80..0).
- BIT_AND / BIT_OR / BIT_XOR / BIT_NOT: bitwise operation; BIT_NOT uses a only. carry_out = overflow = 0.
- SHIFT_LEFT: y = {a[W-2:0], 0}, carry_out = a[W-1].
- SHIFT_RIGHT: y = {0, a[W-1:1]}, carry_out = a[0].
- ROTATE_LEFT (through carry): y = {a[W-2:0], carry_in}, carry_out = a[W-1].
- ROTATE_RIGHT (through carry): y = {carry_in, a[W-1:1]}, carry_out = a[0].
- Shifts and rotates: overflow = 0.
- All non-MULTIPLY ops: zero = (y == 0), sign = y[W-1], y_high = 0.
- MULTIPLY: unsigned a×b by shift-add, one partial-product step per cycle; carry_in ignored.
  - Acceptance: IDLE→MUL, latch a and b, clear accumulator, iteration counter = 0.
  - After WIDTH iterations: load {y_high, y}, out_valid=1, →IDLE.
  - Flags: zero = (full product == 0), sign = y_high[W-1], carry_out = overflow = (y_high != 0).
- Illegal opcode: y = y_high = 0, zero=1, other flags 0, illegal=1, single-cycle path.
- Output register is loaded only on acceptance (single-cycle op) or on MULTIPLY completion. It holds its value while out_valid && !out_ready.
- out_valid is cleared on out_ready unless a new result loads in the same cycle.

## Timing
- Reset: state=IDLE, out_valid=0, y=y_high=0, all flags 0, illegal=0, busy=0, in_ready=0 while reset is high.
- Reset mid-multiply: aborts with no result; block is IDLE on the next cycle.
- Single-cycle ops: accepted at edge N, out_valid=1 with result after edge N. Full throughput of 1/cycle while out_ready=1.
- MULTIPLY: accepted at edge N, busy=1 from N through N+WIDTH−1, result valid after edge N+WIDTH. in_ready=0 throughout.
- Backpressure: out_valid && !out_ready → in_ready=0, no acceptance, outputs stable.
- Simultaneous consume and accept in one cycle is legal; the new result replaces the old one with no bubble.
- MULTIPLY completion with a stale result still pending cannot occur, because acceptance requires the output slot free or draining.

## Test plan
- WIDTH=8, out_ready=1, back-to-back ADD carry_in=0:
  - 208+144 → y=96, C=1, V=1.
  - 208+48 → y=0, Z=1, C=1, V=0.
  - 80+80 → y=160, S=1, V=1.
  - Results appear on consecutive cycles.
- SUBTRACT and carry ops:
  - 80−100 → y=236, S=1, C=1, V=0.
  - 80−176 → y=160, C=1, V=1.
  - 208−112 → y=96, C=0, V=1.
  - ADD 255+0 with carry_in=1 → y=0, Z=1, C=1.
- Shift/rotate, carry_in=1:
  - SHIFT_LEFT 136 → y=16, C=1.
  - ROTATE_LEFT 8 → y=17, C=0.
  - ROTATE_RIGHT 9 → y=132, C=1, S=1.
- MULTIPLY 200×150, WIDTH=8:
  - busy for 8 cycles, then y_high=117, y=48, C=V=1.
  - 0×77 → Z=1.
  - WIDTH=16: 300×300 → y_high=1, y=24464.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after a result: y and flags stable, in_ready=0.
  - Release: the queued input is accepted on the same edge the old result is consumed.
- Reset asserted at iteration 3 of a multiply → out_valid stays 0. Next ADD 1+1 → y=2 one cycle after acceptance. Opcode 14 → illegal=1, Z=1.
